// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_PAUSE = 1'b1;

endpackage

// File: rtl/stopwatch_counter_bcd_digit_counter.sv
// One BCD digit: increments on inc, wraps MAX->0 with carry, clr forces 0 (field wrap).
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output bcd_t q,
  output logic carry
);

  localparam bcd_t MAX_D = bcd_t'(MAX);

  bcd_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == MAX_D) ? '0 : r_q + 4'd1;
    end
  end

  assign q     = r_q;
  assign carry = inc & (r_q == MAX_D);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core with run/pause and per-field adjust; digits update on the tick edge.
// Optional lap display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 99,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oneHz,
  input  logic       twoHz,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  input  logic       lap,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running
);

  localparam bcd_t SEC_T_MAX = bcd_t'(SEC_MAX / 10);
  localparam bcd_t SEC_O_MAX = bcd_t'(SEC_MAX % 10);
  localparam bcd_t MIN_T_MAX = bcd_t'(MIN_MAX / 10);
  localparam bcd_t MIN_O_MAX = bcd_t'(MIN_MAX % 10);

  logic       r_prev1;
  logic       r_prev2;
  logic [0:0] r_state;

  logic w_tick1, w_tick2;
  logic w_sec_inc, w_sec_wrap, w_min_inc, w_min_wrap;
  logic w_sec_at_max, w_min_at_max;
  logic w_so_carry, w_st_carry, w_mo_carry, w_mt_carry;
  bcd_t w_so, w_st, w_mo, w_mt;
  logic [15:0] w_live;
  logic [15:0] w_show;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev1 <= 1'b0;
      r_prev2 <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_prev1 <= oneHz;
      r_prev2 <= twoHz;
      if (pause_p) begin
        r_state <= (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
    end
  end

  assign w_tick1 = oneHz & ~r_prev1;
  assign w_tick2 = twoHz & ~r_prev2;

  assign w_sec_at_max = (w_st == SEC_T_MAX) && (w_so == SEC_O_MAX);
  assign w_min_at_max = (w_mt == MIN_T_MAX) && (w_mo == MIN_O_MAX);

  // Adjust overrides counting; in adjust the seconds wrap never carries into minutes.
  assign w_sec_inc  = adj ? (w_tick2 & sel) : ((r_state == ST_RUN) & w_tick1);
  assign w_sec_wrap = w_sec_inc & w_sec_at_max;
  assign w_min_inc  = adj ? (w_tick2 & ~sel) : w_sec_wrap;
  assign w_min_wrap = w_min_inc & w_min_at_max;

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .inc(w_sec_inc), .clr(w_sec_wrap), .q(w_so), .carry(w_so_carry)
  );
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .inc(w_so_carry), .clr(w_sec_wrap), .q(w_st), .carry(w_st_carry)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .inc(w_min_inc), .clr(w_min_wrap), .q(w_mo), .carry(w_mo_carry)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .inc(w_mo_carry), .clr(w_min_wrap), .q(w_mt), .carry(w_mt_carry)
  );

  assign w_live = {w_mt, w_mo, w_st, w_so};

`ifdef STOPWATCH_LAP_EN
  logic        r_lap_prev;
  logic [15:0] r_lap_dig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_prev <= 1'b0;
      r_lap_dig  <= '0;
    end else begin
      r_lap_prev <= lap;
      if (lap & ~r_lap_prev) begin
        r_lap_dig <= w_live;
      end
    end
  end

  // Until the capture edge, and as soon as lap drops, the live count shows through.
  assign w_show = (lap & r_lap_prev) ? r_lap_dig : w_live;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;
  assign w_show = w_live;
`endif

  logic w_carry_unused;
  assign w_carry_unused = w_st_carry | w_mt_carry;

  assign min_tens = w_show[15:12];
  assign min_ones = w_show[11:8];
  assign sec_tens = w_show[7:4];
  assign sec_ones = w_show[3:0];
  assign running  = (r_state == ST_RUN) & ~adj;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: stimulus queues expected MM:SS+running, monitor compares.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       oneHz = 1'b0, twoHz = 1'b0, pause_p = 1'b0;
  logic       adj = 1'b0, sel = 1'b0, lap = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running;

  stopwatch_counter dut (
    .clk(clk), .rst(rst), .oneHz(oneHz), .twoHz(twoHz), .pause_p(pause_p),
    .adj(adj), .sel(sel), .lap(lap),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] val;
  } exp_t;

  exp_t exp_q[$];
  logic sample_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (sample_req) begin
      logic [16:0] act;
      exp_t        e;
      act = {min_tens, min_ones, sec_tens, sec_ones, running};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output sampled with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (act !== e.val)
          begin
            errors++;
            $display("FAIL %s: got %h%h:%h%h run=%b, expected %h%h:%h%h run=%b", e.name,
                     act[16:13], act[12:9], act[8:5], act[4:1], act[0],
                     e.val[16:13], e.val[12:9], e.val[8:5], e.val[4:1], e.val[0]);
          end
      end
    end
  end

  task automatic expect_now(input string name, input int mm, input int ss, input logic run);
    exp_t e;
    e.name = name;
    e.val  = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run};
    exp_q.push_back(e);
    sample_req = 1'b1;
    @(negedge clk);
    #1 sample_req = 1'b0;
  endtask

  task automatic pulse1(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 oneHz = 1'b1;
      @(posedge clk); #1 oneHz = 1'b0;
    end
  endtask

  task automatic pulse2(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 twoHz = 1'b1;
      @(posedge clk); #1 twoHz = 1'b0;
    end
  endtask

  task automatic pause_pulse();
    @(posedge clk); #1 pause_p = 1'b1;
    @(posedge clk); #1 pause_p = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #12;
    expect_now("reset_state", 0, 0, 1'b1);
    @(posedge clk); #1 rst = 1'b0;

    pulse1(59);
    expect_now("count_59", 0, 59, 1'b1);
    pulse1(1);
    expect_now("count_60_carry", 1, 0, 1'b1);

    // Preload 99:59 through adjust
    @(posedge clk); #1 adj = 1'b1; sel = 1'b0;
    pulse2(98);
    @(posedge clk); #1 sel = 1'b1;
    pulse2(59);
    expect_now("preload_9959_adj", 99, 59, 1'b0);
    @(posedge clk); #1 adj = 1'b0;
    expect_now("adj_release_running", 99, 59, 1'b1);
    pulse1(1);
    expect_now("wrap_9959", 0, 0, 1'b1);

    pause_pulse();
    expect_now("paused", 0, 0, 1'b0);
    pulse1(5);
    expect_now("paused_hold", 0, 0, 1'b0);
    pause_pulse();
    pulse1(1);
    expect_now("resume_plus1", 0, 1, 1'b1);

    @(posedge clk); #1 adj = 1'b1; sel = 1'b1;
    pulse2(57);
    expect_now("adj_sec_58", 0, 58, 1'b0);
    pulse2(3);
    expect_now("adj_sec_wrap_nocarry", 0, 1, 1'b0);
    @(posedge clk); #1 sel = 1'b0;
    pulse2(2);
    expect_now("adj_min_2", 2, 1, 1'b0);
    @(posedge clk); #1 adj = 1'b0;

    do_reset();
    pulse1(10);
    expect_now("count_10", 0, 10, 1'b1);
    @(posedge clk); #1 oneHz = 1'b1; pause_p = 1'b1;
    @(posedge clk); #1 oneHz = 1'b0; pause_p = 1'b0;
    expect_now("pause_with_tick", 0, 11, 1'b0);
    pause_pulse();

    @(posedge clk); #1 adj = 1'b1; sel = 1'b0;
    pulse2(5);
    @(posedge clk); #1 sel = 1'b1;
    pulse2(21);
    @(posedge clk); #1 adj = 1'b0;
    expect_now("at_0532", 5, 32, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    expect_now("async_reset_mid", 0, 0, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    pulse1(1);
    expect_now("first_after_reset", 0, 1, 1'b1);

    @(posedge clk); #1 oneHz = 1'b1;
    repeat (5) @(posedge clk);
    #1 oneHz = 1'b0;
    expect_now("held_level_once", 0, 2, 1'b1);

    @(posedge clk); #1 oneHz = 1'b1; adj = 1'b1; sel = 1'b1;
    @(posedge clk); #1 oneHz = 1'b0;
    expect_now("adj_priority_tick1", 0, 2, 1'b0);
    @(posedge clk); #1 adj = 1'b0;

`ifdef STOPWATCH_LAP_EN
    do_reset();
    pulse1(7);
    @(posedge clk); #1 lap = 1'b1;
    pulse1(4);
    expect_now("lap_hold", 0, 7, 1'b1);
    #1 lap = 1'b0;
    #1 expect_now("lap_release_live", 0, 11, 1'b1);
`else
    @(posedge clk); #1 lap = 1'b1;
    pulse1(4);
    expect_now("lap_ignored", 0, 6, 1'b1);
    #1 lap = 1'b0;
`endif

    begin : drain
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the lab3 stopwatch, directly downstream of the clock divider. Consumes the divider's `oneHz` and `twoHz` outputs and produces four BCD digits, MM:SS, for the seven-segment display stage. Supports run/pause and per-field adjust. All logic runs on the single system clock; the divider outputs are treated as same-domain levels and edge-detected.

## Interface
Parameters:
- `MIN_MAX`, default 99: highest minute value before wrap to 00.
- `SEC_MAX`, default 59: highest second value before wrap to 00.

Ports:
- `clk`  in  1  system clock (same clock as the divider).
- `rst`  in  1  reset; asynchronous, active-high.
- `oneHz`  in  1  divider output, counting rate in run mode.
- `twoHz`  in  1  divider output, adjust rate.
- `pause_p`  in  1  single-cycle debounced pulse; toggles run/pause.
- `adj`  in  1  level; 1 selects adjust mode.
- `sel`  in  1  level; in adjust, 0 selects minutes, 1 selects seconds.
- `lap`  in  1  level; display freeze (see Configuration).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits.
- `running`  out  1  1 when in RUN and `adj`=0.

## Operation
- Edge detect: `oneHz` and `twoHz` each have a previous-value register.
  - `tick1 = oneHz & ~prev1`; `tick2 = twoHz & ~prev2`.
  - Each is one cycle wide per rising edge.
- State machine with states RUN and PAUSE:
  - Reset goes to RUN.
  - `pause_p`=1 toggles the state, including while `adj`=1.
- Adjust overlay (`adj`=1):
  - Normal counting is suppressed in either state.
  - On `tick2`, only the selected field increments.
  - Seconds wrap SEC_MAX→00 with no carry into minutes.
  - Minutes wrap MIN_MAX→00.
  - On `adj` falling, the pre-existing RUN/PAUSE state resumes.
- Run counting (RUN and `adj`=0): on `tick1`, seconds increment.
  - At SEC_MAX, seconds wrap to 00 and carry into minutes.
  - At MIN_MAX:SEC_MAX, the count wraps to 00:00.
- PAUSE with `adj`=0: digits hold; `tick1` is ignored.
- Arithmetic is pure BCD per digit:
  - Ones digits wrap 9→0 with carry to tens.
  - Seconds tens wraps at 5 when ones carries and the value is 59.
  - Digit outputs never exceed 9; `sec_tens` never exceeds 5.
- Reset: all digits 0, `running`=1, `prev1`/`prev2` 0, lap latch cleared.

## Timing
- Digits update on the first `clk` edge that samples `oneHz` (run) or `twoHz` (adjust) high after a low sample. No added latency.
- A level held high produces exactly one increment.
- `running` updates on the edge after `pause_p`, and combinationally with `adj`.
- If `pause_p` and `tick1` occur in the same cycle, the tick is processed under the pre-toggle state.
  - RUN + `pause_p` + `tick1`: count increments, then the state becomes PAUSE.
- A `sel` change in the same cycle as `tick2` uses the new `sel` value, since `sel` is sampled at that edge.
- If `adj` rises in the same cycle as `tick1`, no run increment occurs; adjust has priority.
- `rst` asserted mid-operation clears everything immediately, asynchronously. The first count after release is 00:01 at the next `oneHz` rising edge.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - While `lap`=1, the digit outputs hold the value captured on `lap` rising.
  - The internal count keeps running.
  - On `lap`=0, the outputs show the live count in the same cycle.
- `STOPWATCH_LAP_EN` undefined: `lap` is ignored, and the outputs always equal the internal count.

## Structure
- `stopwatch_pkg` holds:
  - the BCD digit type (4 bits);
  - constants `SEC_TENS_MAX`=5 and `DIGIT_MAX`=9;
  - the state encoding for RUN/PAUSE.
- Sub-module `bcd_digit_counter`:
  - one digit with parameterised max value, `inc` in, `carry` out, and async reset;
  - instantiated four times, with tens carry chained from ones.

## Test plan
- Reset, then 60 `oneHz` rising edges → 01:00; 59 edges → 00:59; `running`=1.
- Preload to 99:59 via adjust, then one `oneHz` edge → 00:00.
- `pause_p` pulse, then 5 `oneHz` edges → digits unchanged. Second `pause_p`, then 1 edge → +1 s.
- `adj`=1, `sel`=1 at 00:58, then 3 `twoHz` edges → 00:01 with minutes still 00. `sel`=0, 2 edges → 02:01.
- `pause_p` coincident with a `oneHz` edge while in RUN at 00:10 → 00:11 and `running`=0 the next cycle. Assert `rst` mid-count at 05:32 → 00:00 immediately.
- With `STOPWATCH_LAP_EN`: raise `lap` at 00:07, then 4 edges → outputs hold 00:07. Drop `lap` → outputs show 00:11.
